// File: rtl/br_trace_sequencer_pkg.sv
// br_trace_sequencer_pkg: trace entry layout and sequencer FSM encoding
package br_trace_sequencer_pkg;
  localparam int INST_LEN = 32;
  localparam int TKN_LEN = 1;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  typedef logic [2:0] state_t;
  // entry packs {TRG_PC, TKN, INST, PC} with PC in the low bits
  function automatic int entry_len(input int pc_len);
    return pc_len + INST_LEN + TKN_LEN + pc_len;
  endfunction
endpackage

// File: rtl/br_pipe_emul.sv
// br_pipe_emul: valid-tagged shift register standing in for the fetch-to-EX pipeline
module br_pipe_emul #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [W-1:0]     in_data_i,
  input  logic [DEPTH-1:0] flush_i,
  output logic [DEPTH-1:0] valid_o,
  output logic [W-1:0]     data_o
);
  logic [DEPTH-1:0] v_q;
  logic [W-1:0] d_q [DEPTH];
  // flush_i[i] squashes whatever would land in slot i this edge; the oldest slot always leaves
  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else begin
      v_q[0] <= in_valid_i & ~flush_i[0];
      for (int i = 1; i < DEPTH; i++) v_q[i] <= v_q[i-1] & ~flush_i[i];
    end
  end
  // payload moves unconditionally; only the valid tags carry meaning
  always_ff @(posedge clk) begin
    d_q[0] <= in_data_i;
    for (int i = 1; i < DEPTH; i++) d_q[i] <= d_q[i-1];
  end
  assign valid_o = v_q;
  assign data_o = d_q[DEPTH-1];
endmodule

// File: rtl/br_trace_sequencer.sv
// br_trace_sequencer: replays a branch trace through a predictor with an emulated fetch-to-EX pipe
module br_trace_sequencer
  import br_trace_sequencer_pkg::*;
#(
  parameter int BRANCH_COUNT = 16,
  parameter int SIM_LEN = 1,
  parameter int EX_STAGE_LOC = 3,
  parameter int PC_LEN = 32,
  parameter int MAX_GAP = 256,
  localparam int PTR_W = $clog2(BRANCH_COUNT),
  localparam int ENTRY_LEN = entry_len(PC_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [PTR_W-1:0]     trace_addr,
  input  logic [ENTRY_LEN-1:0] trace_entry,
  output logic                 pred_req_valid,
  output logic [PC_LEN-1:0]    pred_req_pc,
  input  logic                 pred_taken,
  input  logic [PC_LEN-1:0]    pred_target,
  output logic                 upd_valid,
  output logic [PC_LEN-1:0]    upd_pc,
  output logic                 upd_taken,
  output logic [PC_LEN-1:0]    upd_target,
  output logic                 upd_mispredict,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          branch_cnt,
  output logic [31:0]          mispred_cnt
);
  localparam int DEPTH = EX_STAGE_LOC - 1;
  localparam int PASS_W = $clog2(SIM_LEN + 1);
  localparam int WD_W = $clog2(MAX_GAP + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(BRANCH_COUNT - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(SIM_LEN - 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_GAP);
  localparam logic [PC_LEN-1:0] STEP = PC_LEN'(4);
  // low four fields mirror the trace entry so a slot is {tags, prediction, entry}
  typedef struct packed {
    logic [PASS_W-1:0]   pass;
    logic [PTR_W-1:0]    idx;
    logic [PC_LEN-1:0]   ptgt;
    logic                ptkn;
    logic [PC_LEN-1:0]   trg;
    logic                tkn;
    logic [INST_LEN-1:0] inst;
    logic [PC_LEN-1:0]   pc;
  } slot_t;
  localparam int SLOT_W = $bits(slot_t);
  state_t state_q, state_d;
  logic [PC_LEN-1:0] pc_q, pc_d, first_pc_q, first_pc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic err_q, err_d;
  logic [31:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;
  logic [DEPTH-1:0] pv;
  logic [SLOT_W-1:0] ex_raw;
  slot_t fe, ex;
  logic run, match, last, ex_v, mis, redir, wd_fire;
  logic unused;
  assign fe = {pass_q, ptr_q, pred_target, pred_taken, trace_entry};
  assign ex = ex_raw;
  assign unused = ^ex.inst;
  assign run = state_q == S_RUN;
  assign match = run && pc_q == fe.pc;
  assign last = ptr_q == LAST;
  assign ex_v = pv[DEPTH-1];
  assign mis = ex_v && (ex.ptkn != ex.tkn || (ex.tkn && ex.ptgt != ex.trg));
  assign redir = mis && ex.idx != LAST;
  assign wd_fire = run && !match && !redir && wd_q == WD_MAX;
  br_pipe_emul #(.W(SLOT_W), .DEPTH(DEPTH)) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (match),
    .in_data_i  (fe),
    .flush_i    ({DEPTH{redir || wd_fire}}),
    .valid_o    (pv),
    .data_o     (ex_raw)
  );
  // FSM, fetch PC and trace pointer; a redirect from EX beats anything fetch wants this cycle
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    first_pc_d = first_pc_q;
    ptr_d = ptr_q;
    pass_d = pass_q;
    wd_d = wd_q;
    err_d = err_q;
    bcnt_d = bcnt_q + 32'(ex_v);
    mcnt_d = mcnt_q + 32'(mis);
    if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
      state_d = S_LOAD;
      bcnt_d = '0;
      mcnt_d = '0;
      err_d = 1'b0;
    end else if (state_q == S_LOAD) begin
      state_d = S_RUN;
      pc_d = fe.pc;
      first_pc_d = fe.pc;
      ptr_d = '0;
      pass_d = '0;
      wd_d = '0;
    end else if (redir) begin
      state_d = S_RUN;
      pc_d = ex.tkn ? ex.trg : ex.pc + STEP;
      ptr_d = ex.idx + PTR_W'(1);
      pass_d = ex.pass;
      wd_d = '0;
    end else if (wd_fire) begin
      state_d = S_DONE;
      err_d = 1'b1;
    end else if (match) begin
      ptr_d = last ? '0 : ptr_q + PTR_W'(1);
      pass_d = pass_q + PASS_W'(last);
      pc_d = last ? first_pc_q : fe.ptkn ? fe.ptgt : pc_q + STEP;
      wd_d = '0;
      state_d = last && pass_q == LAST_PASS ? S_DRAIN : S_RUN;
    end else if (run) begin
      pc_d = pc_q + STEP;
      wd_d = wd_q + WD_W'(1);
    end else if (state_q == S_DRAIN && pv == '0) begin
      state_d = S_DONE;
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      first_pc_q <= '0;
      ptr_q <= '0;
      pass_q <= '0;
      wd_q <= '0;
      err_q <= 1'b0;
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      first_pc_q <= first_pc_d;
      ptr_q <= ptr_d;
      pass_q <= pass_d;
      wd_q <= wd_d;
      err_q <= err_d;
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end
  assign trace_addr = state_q == S_LOAD ? '0 : ptr_q;
  assign pred_req_valid = match;
  assign pred_req_pc = pc_q;
  assign upd_valid = ex_v;
  assign upd_pc = ex_v ? ex.pc : '0;
  assign upd_taken = ex_v && ex.tkn;
  assign upd_target = ex_v ? ex.trg : '0;
  assign upd_mispredict = mis;
  assign busy = state_q == S_LOAD || state_q == S_RUN || state_q == S_DRAIN;
  assign done = state_q == S_DONE;
  assign error = err_q;
  assign branch_cnt = bcnt_q;
  assign mispred_cnt = mcnt_q;
endmodule
